// File: rtl/jtopl_ch_wr_sched_pkg.sv
// jtopl_ch_wr_sched_pkg: shared slot/channel constants, pending-write record and channel index helper
package jtopl_ch_wr_sched_pkg;
  localparam int CHCSRW = 10;
  localparam int NCH = 9;
  localparam int NSLOT = 18;
  localparam int NGROUP = 3;
  typedef struct packed {
    logic [3:0] ch;
    logic [CHCSRW-1:0] data;
    logic [CHCSRW-1:0] mask;
  } pend_t;
  function automatic logic [3:0] ch_of(input logic [1:0] g, input logic [1:0] s);
    return {s, 1'b0} + {2'b0, s} + {2'b0, g};
  endfunction
endpackage

// File: rtl/jtopl_ch_wr_sched_if.sv
// jtopl_ch_wr_sched_if: host write channel (valid/ready request, ch/data/mask payload, commit/err pulses)
interface jtopl_ch_wr_sched_if;
  import jtopl_ch_wr_sched_pkg::*;
  logic wr_valid;
  logic wr_ready;
  logic [3:0] wr_ch;
  logic [CHCSRW-1:0] wr_data;
  logic [CHCSRW-1:0] wr_mask;
  logic wr_commit;
  logic wr_err;
  modport master(output wr_valid, wr_ch, wr_data, wr_mask, input wr_ready, wr_commit, wr_err);
  modport slave(input wr_valid, wr_ch, wr_data, wr_mask, output wr_ready, wr_commit, wr_err);
endinterface

// File: rtl/jtopl_slot_seq.sv
// jtopl_slot_seq: 18-slot operator sequencer; clk/rst/cen in, one-hot slot, group, zero marker and cur_ch out
module jtopl_slot_seq
  import jtopl_ch_wr_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  output logic [NSLOT-1:0] slot,
  output logic [1:0]       group,
  output logic             zero,
  output logic [3:0]       cur_ch
);
  logic [1:0] sub;
  logic       op;
  logic [4:0] s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      group <= 2'd0;
      sub   <= 2'd0;
      op    <= 1'b0;
    end else if (cen) begin
      group <= group == 2'd2 ? 2'd0 : group + 2'd1;
      if (group == 2'd2) sub <= sub == 2'd2 ? 2'd0 : sub + 2'd1;
      if (group == 2'd2 && sub == 2'd2) op <= ~op;
    end
  end
  always_comb begin
    cur_ch = ch_of(group, sub);
    s      = (op ? 5'd9 : 5'd0) + {1'b0, cur_ch};
    slot   = NSLOT'(1) << s;
    zero   = s == 5'd0;
  end
endmodule

// File: rtl/jtopl_ch_wr_sched.sv
// jtopl_ch_wr_sched: slot sequencer plus single-entry host write scheduler; ports clk/rst/cen, slot/group/zero timing, chcfg in, chcfg_inmux out, wr host interface
module jtopl_ch_wr_sched
  import jtopl_ch_wr_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  output logic [NSLOT-1:0]  slot,
  output logic [1:0]        group,
  output logic              zero,
  input  logic [CHCSRW-1:0] chcfg,
  output logic [CHCSRW-1:0] chcfg_inmux,
  jtopl_ch_wr_sched_if.slave wr
);
  logic [3:0] cur_ch;
  pend_t      pend;
  logic       pend_v;
  logic       hit;
  logic       xfer;
  jtopl_slot_seq u_seq (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .slot   (slot),
    .group  (group),
    .zero   (zero),
    .cur_ch (cur_ch)
  );
  assign wr.wr_ready = ~pend_v;
  always_comb begin
    xfer        = wr.wr_valid & ~pend_v;
    hit         = pend_v & cen & (cur_ch == pend.ch);
    chcfg_inmux = hit ? (chcfg & ~pend.mask) | (pend.data & pend.mask) : chcfg;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v       <= 1'b0;
      pend         <= '0;
      wr.wr_commit <= 1'b0;
      wr.wr_err    <= 1'b0;
    end else begin
      wr.wr_commit <= hit;
      wr.wr_err    <= xfer & (wr.wr_ch >= 4'(NCH));
      if (hit) pend_v <= 1'b0;
      else if (xfer && wr.wr_ch < 4'(NCH)) begin
        pend_v <= 1'b1;
        pend   <= '{ch: wr.wr_ch, data: wr.wr_data, mask: wr.wr_mask};
      end
    end
  end
endmodule

// File: tb/tb_jtopl_ch_wr_sched.sv
// tb_jtopl_ch_wr_sched: table vectors, directed corner sequences and random traffic against a slot-index reference model
module tb_jtopl_ch_wr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b0;
  logic [17:0] slot;
  logic [1:0] group;
  logic zero;
  logic [9:0] chcfg = '0;
  logic [9:0] chcfg_inmux;
  int tests = 0;
  int fails = 0;
  int k;
  logic pv, mc, me;
  logic [3:0] pch;
  logic [9:0] pd, pm;
  logic obs_commit, obs_err, obs_ready;
  logic [9:0] obs_inmux;
  logic [9:0] mem [9];

  jtopl_ch_wr_sched_if wr();

  jtopl_ch_wr_sched dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .slot        (slot),
    .group       (group),
    .zero        (zero),
    .chcfg       (chcfg),
    .chcfg_inmux (chcfg_inmux),
    .wr          (wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic c, v;
    logic [3:0] ch;
    logic [9:0] d, m, cf;
    logic [9:0] e_inmux;
    logic e_ready, e_commit;
  } vec_t;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    cen = 1'b0;
    wr.wr_valid = 1'b0;
    #1;
    k = 0; pv = 1'b0; mc = 1'b0; me = 1'b0;
    chk("rst_slot", 32'(slot), 32'h1);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_group", 32'(group), 32'h0);
    chk("rst_ready", 32'(wr.wr_ready), 32'h1);
    chk("rst_commit", 32'(wr.wr_commit), 32'h0);
    chk("rst_err", 32'(wr.wr_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick(input logic c, input logic v, input logic [3:0] ch,
                      input logic [9:0] d, input logic [9:0] m, input logic [9:0] cf);
    logic h;
    int cc;
    cen = c; wr.wr_valid = v; wr.wr_ch = ch; wr.wr_data = d; wr.wr_mask = m; chcfg = cf;
    #1;
    cc = k % 9;
    h = pv && c && (cc == int'(pch));
    chk("slot", 32'(slot), 32'(18'h1 << k));
    chk("group", 32'(group), 32'(cc % 3));
    chk("zero", 32'(zero), 32'(k == 0));
    chk("ready", 32'(wr.wr_ready), 32'(!pv));
    chk("commit", 32'(wr.wr_commit), 32'(mc));
    chk("err", 32'(wr.wr_err), 32'(me));
    chk("inmux", 32'(chcfg_inmux), 32'(h ? ((cf & ~pm) | (pd & pm)) : cf));
    obs_commit = wr.wr_commit; obs_err = wr.wr_err; obs_ready = wr.wr_ready; obs_inmux = chcfg_inmux;
    @(posedge clk);
    mc = h;
    me = v && !pv && ch > 4'd8;
    if (h) pv = 1'b0;
    else if (v && !pv && ch <= 4'd8) begin
      pv = 1'b1; pch = ch; pd = d; pm = m;
    end
    if (c) k = (k + 1) % 18;
    @(negedge clk);
  endtask

  initial begin
    vec_t tbl [7];
    int n, nc, ne;
    bit done;
    logic [9:0] cf;
    wr.wr_valid = 1'b0; wr.wr_ch = '0; wr.wr_data = '0; wr.wr_mask = '0;
    pch = '0; pd = '0; pm = '0;
    tbl[0] = '{1'b1, 1'b1, 4'd4, 10'h3FF, 10'h00F, 10'h200, 10'h200, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 4'd0, 10'h000, 10'h000, 10'h200, 10'h200, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 4'd0, 10'h000, 10'h000, 10'h200, 10'h200, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 4'd0, 10'h000, 10'h000, 10'h200, 10'h200, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 4'd0, 10'h000, 10'h000, 10'h200, 10'h20F, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 4'd0, 10'h000, 10'h000, 10'h200, 10'h200, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 4'd0, 10'h000, 10'h000, 10'h200, 10'h200, 1'b1, 1'b0};
    do_reset();
    // slot walk over a full frame
    for (int i = 0; i < 18; i++) tick(1'b1, 1'b0, 4'd0, 10'h0, 10'h0, 10'($urandom));
    #1;
    chk("t1_wrap_slot", 32'(slot), 32'h1);
    // table: write ch4 at s=0 commits at s=4
    for (int i = 0; i < 7; i++) begin
      tick(tbl[i].c, tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].m, tbl[i].cf);
      chk($sformatf("t2_inmux_%0d", i), 32'(obs_inmux), 32'(tbl[i].e_inmux));
      chk($sformatf("t2_ready_%0d", i), 32'(obs_ready), 32'(tbl[i].e_ready));
      chk($sformatf("t2_commit_%0d", i), 32'(obs_commit), 32'(tbl[i].e_commit));
    end
    // write ch0 accepted at s=0 waits for s=9
    for (int i = 0; i < 18 && k != 0; i++) tick(1'b1, 1'b0, 4'd0, 10'h0, 10'h0, 10'($urandom));
    tick(1'b1, 1'b1, 4'd0, 10'h0AB, 10'h3FF, 10'h155);
    n = 0; done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick(1'b1, 1'b0, 4'd0, 10'h0, 10'h0, 10'($urandom));
      n++;
      done = obs_commit;
    end
    chk("t3_latency", 32'(n - 1), 32'd9);
    // out-of-range channel
    nc = 0; ne = 0;
    tick(1'b1, 1'b1, 4'd12, 10'h3FF, 10'h3FF, 10'h0);
    for (int i = 0; i < 18; i++) begin
      tick(1'b1, 1'b0, 4'd0, 10'h0, 10'h0, 10'($urandom));
      nc += int'(obs_commit); ne += int'(obs_err);
    end
    chk("t4_commits", 32'(nc), 32'd0);
    chk("t4_errs", 32'(ne), 32'd1);
    // two serialised writes to ch2 against an emulated datapath store
    for (int i = 0; i < 9; i++) mem[i] = 10'($urandom);
    mem[2] = 10'h000;
    n = 0; nc = 0;
    for (int i = 0; i < 60 && nc < 2; i++) begin
      logic v2;
      logic [9:0] d2, m2;
      int cc;
      cc = k % 9;
      v2 = (n < 2);
      d2 = (n == 0) ? 10'h155 : 10'h2AA;
      m2 = (n == 0) ? 10'h300 : 10'h0FF;
      if (v2 && !pv) n++;
      tick(1'b1, v2, 4'd2, d2, m2, mem[cc]);
      mem[cc] = obs_inmux;
      nc += int'(obs_commit);
      if (n == 2 && nc == 0) chk("t5_order", 32'(nc), 32'd1);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 4'd0, 10'h0, 10'h0, mem[k % 9]);
    chk("t5_word", 32'(mem[2]), 32'h1AA);
    // pending write frozen by cen low, then lost to reset
    tick(k % 9 == 8 ? 1'b0 : 1'b1, 1'b1, 4'd8, 10'h3FF, 10'h3FF, 10'h0);
    nc = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, 4'd0, 10'h0, 10'h0, 10'($urandom));
      nc += int'(obs_commit);
    end
    do_reset();
    chk("t6_commits", 32'(nc), 32'd0);
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, 1'b0, 4'd0, 10'h0, 10'h0, 10'($urandom));
      chk("t6_no_commit", 32'(obs_commit), 32'd0);
    end
    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cf = 10'($urandom);
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8)),
           10'($urandom), $urandom_range(0, 7) == 0 ? 10'h0 : 10'($urandom), cf);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jtopl_ch_wr_sched.md
Name: jtopl_ch_wr_sched

Overview:
Slot sequencer and host-write scheduler for the per-channel configuration shift registers (3 groups × 3 stages, CHCSRW bits each).
- Generates the 18-slot operator timing (one-hot slot, group select, frame-zero marker).
- Accepts one host channel-register write at a time and holds it until the target channel's stage is presented.
- On that cycle, drives the merged value onto chcfg_inmux; all other cycles recirculate chcfg unchanged.

Parameters:
CHCSRW, 10, width of one channel configuration word.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
cen  input  1  clock enable; one slot per cen cycle
slot  output  18  one-hot current operator slot
group  output  2  current channel group (0..2), drives datapath group select
zero  output  1  high while slot 0 is current
chcfg  input  CHCSRW  current channel word returned by datapath
chcfg_inmux  output  CHCSRW  word to store for the current group
wr_valid  input  1  host write request
wr_ready  output  1  scheduler can accept a write
wr_ch  input  4  target channel 0..8
wr_data  input  CHCSRW  new field bits
wr_mask  input  CHCSRW  1 = replace bit with wr_data
wr_commit  output  1  pulse: pending write stored this cycle
wr_err  output  1  pulse: accepted write had wr_ch > 8, discarded

Behaviour:
- Counters: group (0..2), sub (0..2), op (0..1). Reset to 0, so slot=18'h1 and zero=1.
- Counter advance on cen:
  - group increments mod 3.
  - When group wraps 2→0, sub increments mod 3.
  - When group=2 and sub=2, op toggles.
  - No change without cen.
- Derived indices: cur_ch = 3*sub + group; slot index s = 9*op + cur_ch; slot = 1<<s; zero = (s==0). All are registered-state decodes, no extra latency.
- Frame period: 18 cen cycles. Each channel is presented twice per frame, at op=0 and op=1.
- Pending register fields: pend_v, pend_ch, pend_data, pend_mask. All clear on reset; outputs reset to wr_ready=1, wr_commit=0, wr_err=0.
- Handshake:
  - wr_ready = ~pend_v.
  - Transfer happens on any clk edge with wr_valid & wr_ready; cen is not required.
  - Valid transfer: the request is loaded into the pending register and pend_v is set.
  - Transfer with wr_ch > 8: not loaded. wr_err pulses for 1 clk on the next cycle; wr_ready stays 1.
- Hit = pend_v & cen & (cur_ch == pend_ch).
  - chcfg_inmux = hit ? (chcfg & ~pend_mask) | (pend_data & pend_mask) : chcfg. This path is combinational.
  - On the hit edge: pend_v clears and wr_commit=1 for the following clk.
  - The commit happens on the first matching presentation, regardless of op.
- Latency: commit occurs within 1..9 cen cycles of acceptance. A pending write never waits a full frame.
- Loading is impossible on the hit cycle (wr_ready=0). The earliest next acceptance is the clk after the commit.
- Back-to-back writes to the same channel are serialised. The second write merges against the already-committed word.
- Reset mid-pending: the write is lost, counters restart at slot 0, and no commit pulse occurs.
- cen low while pending: nothing advances and no commit happens. chcfg_inmux = chcfg.
- wr_mask = 0: the commit still occurs and the pulse fires, but data is unchanged.

Decomposition:
- Shared package:
  - NCH=9, NSLOT=18, NGROUP=3.
  - Pending-write struct (ch, data, mask).
  - Function ch_of(group, sub).
- One natural sub-module: jtopl_slot_seq, holding the group/sub/op counters and the slot/zero/cur_ch decode. It is reusable by the timer and envelope blocks.
- The write-pending register and merge logic stay in the top module.

Test Plan:
1. Reset, then 18 cen pulses → slot walks 18'h1 through 18'h20000. group sequence is 0,1,2 repeating; zero high only in cycles 0 and 18; slot returns to 18'h1.
2. At s=0, write ch=4, data=0x3FF, mask=0x00F, with chcfg=0x200 in the datapath → commit at the cen where group=1, sub=1. Required values:
   - chcfg_inmux=0x20F on that cycle, and equal to chcfg on all others.
   - wr_commit pulses once.
   - wr_ready low from acceptance to commit.
3. Write ch=0 accepted exactly when s=0 is current → commit at the next s=9 presentation (9 cens later), not at s=0.
4. Write ch=12 → accepted, wr_err pulses once, no commit pulse, and chcfg_inmux==chcfg for a full frame.
5. Two writes to ch=2 with mask 0x300 then 0x0FF → the second is accepted only after the first commit. Final stored word merges both fields.
6. Pending write to ch=8 with cen held low for 20 clks, then rst pulse → no commit occurs. After reset, slot=18'h1 and wr_ready=1.
